// File: rtl/rv.sv
// Shared core types.
//   regaddr_t  : architectural register index (x0..x31)
//   mem_type_t : access width / signedness of a load or store
//   reg_wsel_t : writeback source select
package rv;

    typedef logic [4:0] regaddr_t;

    typedef enum logic [2:0] {
        MEM_B  = 3'd0,
        MEM_H  = 3'd1,
        MEM_W  = 3'd2,
        MEM_BU = 3'd3,
        MEM_HU = 3'd4
    } mem_type_t;

    typedef enum logic [1:0] {
        REG_WSEL_ALU = 2'd0,
        REG_WSEL_MEM = 2'd1,
        REG_WSEL_PC4 = 2'd2,
        REG_WSEL_CSR = 2'd3
    } reg_wsel_t;

endpackage

// File: rtl/m_if.sv
// Execute -> memory-stage handshake bundle.
//   valid/ready : one instruction per handshake
//   pc, rd, reg_wen, reg_wsel, mem_ren, mem_wen, mem_type,
//   alu_out, alu_sum, imm, csr_value, rs2_data : instruction fields
// master = execute side, slave = memory stage.
interface m_if;
    import rv::*;

    logic        valid;
    logic        ready;
    logic [31:0] pc;
    regaddr_t    rd;
    logic        reg_wen;
    reg_wsel_t   reg_wsel;
    logic        mem_ren;
    logic        mem_wen;
    mem_type_t   mem_type;
    logic [31:0] alu_out;
    logic [31:0] alu_sum;
    logic [31:0] imm;
    logic [31:0] csr_value;
    logic [31:0] rs2_data;

    modport master (
        output valid, pc, rd, reg_wen, reg_wsel, mem_ren, mem_wen, mem_type,
               alu_out, alu_sum, imm, csr_value, rs2_data,
        input  ready
    );

    modport slave (
        input  valid, pc, rd, reg_wen, reg_wsel, mem_ren, mem_wen, mem_type,
               alu_out, alu_sum, imm, csr_value, rs2_data,
        output ready
    );

endinterface

// File: rtl/w_if.sv
// Memory-stage -> writeback handshake bundle.
//   valid/ready : one result per handshake
//   pc, rd, reg_wen, reg_wsel, mem_type, alu_out, alu_sum, imm,
//   csr_value, mem_rdata : result fields (mem_rdata is the raw bus word)
// slave = memory stage (producer), master = writeback (consumer).
interface w_if;
    import rv::*;

    logic        valid;
    logic        ready;
    logic [31:0] pc;
    regaddr_t    rd;
    logic        reg_wen;
    reg_wsel_t   reg_wsel;
    mem_type_t   mem_type;
    logic [31:0] alu_out;
    logic [31:0] alu_sum;
    logic [31:0] imm;
    logic [31:0] csr_value;
    logic [31:0] mem_rdata;

    modport slave (
        output valid, pc, rd, reg_wen, reg_wsel, mem_type, alu_out, alu_sum,
               imm, csr_value, mem_rdata,
        input  ready
    );

    modport master (
        input  valid, pc, rd, reg_wen, reg_wsel, mem_type, alu_out, alu_sum,
               imm, csr_value, mem_rdata,
        output ready
    );

endinterface

// File: rtl/core_store.sv
// Store lane alignment (combinational), counterpart of core_load in writeback.
//   rs2_data  : unaligned store data (low bits significant)
//   mem_type  : store width
//   offset    : byte offset within the word (alu_sum[1:0])
//   bus_wdata : data shifted onto its byte lanes
//   bus_be    : byte enables; bits shifted past lane 3 are dropped
module core_store
    import rv::*;
(
    input  logic [31:0] rs2_data,
    input  mem_type_t   mem_type,
    input  logic [1:0]  offset,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be
);

    assign bus_wdata = rs2_data << {offset, 3'b000};

    always_comb begin
        bus_be = 4'b1111;
        case (mem_type)
            MEM_B, MEM_BU: bus_be = 4'b0001 << offset;
            MEM_H, MEM_HU: bus_be = 4'b0011 << offset;
            default:       bus_be = 4'b1111;
        endcase
    end

endmodule

// File: rtl/core_mem.sv
// Memory-access stage: single instruction slot between execute and writeback.
// Issues at most one data-bus transaction per load/store and forwards the raw
// load word.
//   clk, rst    : clock, synchronous active-high reset
//   m           : instruction from execute (m_if.slave)
//   w           : result to writeback (w_if.slave)
//   dmem_req/we/addr/wdata/be : bus request, held until dmem_gnt
//   dmem_gnt    : request accepted this cycle
//   dmem_rvalid/dmem_rdata    : load response
module core_mem
    import rv::*;
(
    input  logic        clk,
    input  logic        rst,
    m_if.slave          m,
    w_if.slave          w,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {EMPTY, REQ, WAIT, FULL} state_t;

    state_t      state_q;
    logic [31:0] pc_q, alu_out_q, alu_sum_q, imm_q, csr_value_q, mem_rdata_q;
    regaddr_t    rd_q;
    logic        reg_wen_q;
    reg_wsel_t   reg_wsel_q;
    mem_type_t   mem_type_q;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;

    logic        accept;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;

    core_store u_store (
        .rs2_data  (m.rs2_data),
        .mem_type  (m.mem_type),
        .offset    (m.alu_sum[1:0]),
        .bus_wdata (st_wdata),
        .bus_be    (st_be)
    );

    assign m.ready = (state_q == EMPTY) || (state_q == FULL && w.ready);
    assign accept  = m.valid && m.ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            pc_q        <= '0;
            rd_q        <= '0;
            reg_wen_q   <= 1'b0;
            reg_wsel_q  <= REG_WSEL_ALU;
            mem_type_q  <= MEM_B;
            alu_out_q   <= '0;
            alu_sum_q   <= '0;
            imm_q       <= '0;
            csr_value_q <= '0;
            mem_rdata_q <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
        end else if (accept) begin
            // Accept is only possible in EMPTY or in FULL while the old result
            // is consumed, so it always overwrites the whole slot.
            state_q     <= (m.mem_ren || m.mem_wen) ? REQ : FULL;
            pc_q        <= m.pc;
            rd_q        <= m.rd;
            reg_wen_q   <= m.reg_wen;
            reg_wsel_q  <= m.reg_wsel;
            mem_type_q  <= m.mem_type;
            alu_out_q   <= m.alu_out;
            alu_sum_q   <= m.alu_sum;
            imm_q       <= m.imm;
            csr_value_q <= m.csr_value;
            mem_rdata_q <= '0;
            we_q        <= m.mem_wen;
            addr_q      <= {m.alu_sum[31:2], 2'b00};
            wdata_q     <= m.mem_wen ? st_wdata : 32'h0;
            be_q        <= m.mem_wen ? st_be : 4'b0000;
        end else begin
            case (state_q)
                REQ:     if (dmem_gnt) state_q <= we_q ? FULL : WAIT;
                WAIT:    if (dmem_rvalid) begin
                             mem_rdata_q <= dmem_rdata;
                             state_q     <= FULL;
                         end
                FULL:    if (w.ready) state_q <= EMPTY;
                default: state_q <= state_q;
            endcase
        end
    end

    assign dmem_req   = (state_q == REQ);
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;

    assign w.valid     = (state_q == FULL);
    assign w.pc        = pc_q;
    assign w.rd        = rd_q;
    assign w.reg_wen   = reg_wen_q;
    assign w.reg_wsel  = reg_wsel_q;
    assign w.mem_type  = mem_type_q;
    assign w.alu_out   = alu_out_q;
    assign w.alu_sum   = alu_sum_q;
    assign w.imm       = imm_q;
    assign w.csr_value = csr_value_q;
    assign w.mem_rdata = mem_rdata_q;

    a_no_ren_and_wen: assert property (@(posedge clk) disable iff (rst)
        !(m.valid && m.ready && m.mem_ren && m.mem_wen));

    a_rvalid_only_in_wait: assert property (@(posedge clk) disable iff (rst)
        !(dmem_rvalid && state_q != WAIT));

endmodule

// File: tb/tb_core_mem.sv
module tb_core_mem;
    import rv::*;

    logic        clk;
    logic        rst;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    int errors = 0;
    int checks = 0;

    m_if mi ();
    w_if wi ();

    core_mem dut (
        .clk         (clk),
        .rst         (rst),
        .m           (mi),
        .w           (wi),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_be     (dmem_be),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic [31:0] pc, input logic [4:0] rd,
                         input logic ren, input logic wen, input mem_type_t mt,
                         input logic [31:0] sum, input logic [31:0] rs2);
        mi.valid     = 1'b1;
        mi.pc        = pc;
        mi.rd        = rd;
        mi.reg_wen   = !wen;
        mi.reg_wsel  = ren ? REG_WSEL_MEM : REG_WSEL_ALU;
        mi.mem_ren   = ren;
        mi.mem_wen   = wen;
        mi.mem_type  = mt;
        mi.alu_out   = pc + 32'h10;
        mi.alu_sum   = sum;
        mi.imm       = 32'h0000_0800;
        mi.csr_value = 32'h0000_0000;
        mi.rs2_data  = rs2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (wi.valid !== 1'b0) begin errors++; $display("FAIL reset_wvalid: got %b want 0", wi.valid); end
        checks++; if (mi.ready !== 1'b1) begin errors++; $display("FAIL reset_mready: got %b want 1", mi.ready); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", dmem_req); end
        checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", dmem_we); end
        checks++; if (dmem_be !== 4'b0000) begin errors++; $display("FAIL reset_be: got %b want 0000", dmem_be); end
        checks++; if (dmem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", dmem_addr); end
        checks++; if (dmem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", dmem_wdata); end
        checks++; if (wi.pc !== 32'h0 || wi.mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_slot: pc=%h rdata=%h want 0", wi.pc, wi.mem_rdata); end
    endtask

    task automatic test_alu_stream();
        wi.ready = 1'b1;
        set_m(32'h100, 5'd1, 1'b0, 1'b0, MEM_W, 32'h100, 32'h0);
        #1;
        checks++; if (wi.valid !== 1'b0) begin errors++; $display("FAIL alu_pre_valid: got %b want 0", wi.valid); end
        tick();
        set_m(32'h104, 5'd2, 1'b0, 1'b0, MEM_W, 32'h104, 32'h0);
        #1;
        checks++; if (wi.valid !== 1'b1 || wi.pc !== 32'h100) begin errors++; $display("FAIL alu_0: valid=%b pc=%h want 1/00000100", wi.valid, wi.pc); end
        checks++; if (wi.rd !== 5'd1 || wi.alu_out !== 32'h110 || wi.mem_rdata !== 32'h0) begin errors++; $display("FAIL alu_0_fields: rd=%0d alu_out=%h rdata=%h want 1/00000110/0", wi.rd, wi.alu_out, wi.mem_rdata); end
        checks++; if (mi.ready !== 1'b1) begin errors++; $display("FAIL alu_0_mready: got %b want 1", mi.ready); end
        tick();
        set_m(32'h108, 5'd3, 1'b0, 1'b0, MEM_W, 32'h108, 32'h0);
        #1;
        checks++; if (wi.valid !== 1'b1 || wi.pc !== 32'h104 || wi.rd !== 5'd2) begin errors++; $display("FAIL alu_1: valid=%b pc=%h rd=%0d want 1/00000104/2", wi.valid, wi.pc, wi.rd); end
        tick();
        mi.valid = 1'b0;
        #1;
        checks++; if (wi.valid !== 1'b1 || wi.pc !== 32'h108 || wi.alu_sum !== 32'h108) begin errors++; $display("FAIL alu_2: valid=%b pc=%h sum=%h want 1/00000108/00000108", wi.valid, wi.pc, wi.alu_sum); end
        tick();
        checks++; if (wi.valid !== 1'b0) begin errors++; $display("FAIL alu_drain: got %b want 0", wi.valid); end
    endtask

    task automatic test_byte_store();
        wi.ready = 1'b1;
        dmem_gnt = 1'b0;
        set_m(32'h200, 5'd0, 1'b0, 1'b1, MEM_B, 32'h1003, 32'h0000_00AB);
        tick();
        mi.valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dmem_gnt = (i == 2);
            #1;
            checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h1000) begin errors++; $display("FAIL sb_req_%0d: req=%b we=%b addr=%h want 1/1/00001000", i, dmem_req, dmem_we, dmem_addr); end
            checks++; if (dmem_be !== 4'b1000 || dmem_wdata !== 32'hAB00_0000) begin errors++; $display("FAIL sb_lane_%0d: be=%b wdata=%h want 1000/ab000000", i, dmem_be, dmem_wdata); end
            checks++; if (wi.valid !== 1'b0) begin errors++; $display("FAIL sb_wvalid_%0d: got %b want 0", i, wi.valid); end
            tick();
        end
        dmem_gnt = 1'b0;
        #1;
        checks++; if (dmem_req !== 1'b0 || wi.valid !== 1'b1 || wi.pc !== 32'h200) begin errors++; $display("FAIL sb_done: req=%b valid=%b pc=%h want 0/1/00000200", dmem_req, wi.valid, wi.pc); end
        checks++; if (wi.mem_rdata !== 32'h0) begin errors++; $display("FAIL sb_rdata: got %h want 0", wi.mem_rdata); end
        tick();
    endtask

    task automatic test_load_word();
        wi.ready = 1'b1;
        set_m(32'h300, 5'd7, 1'b1, 1'b0, MEM_W, 32'h2000, 32'hFFFF_FFFF);
        tick();
        mi.valid = 1'b0;
        dmem_gnt = 1'b1;
        #1;
        checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h2000 || dmem_be !== 4'b0000) begin errors++; $display("FAIL lw_req: req=%b we=%b addr=%h be=%b want 1/0/00002000/0000", dmem_req, dmem_we, dmem_addr, dmem_be); end
        checks++; if (mi.ready !== 1'b0) begin errors++; $display("FAIL lw_mready_req: got %b want 0", mi.ready); end
        tick();
        dmem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dmem_rvalid = (i == 2);
            dmem_rdata  = (i == 2) ? 32'hDEAD_BEEF : 32'h1111_1111;
            #1;
            checks++; if (dmem_req !== 1'b0 || mi.ready !== 1'b0 || wi.valid !== 1'b0) begin errors++; $display("FAIL lw_wait_%0d: req=%b mready=%b wvalid=%b want 0/0/0", i, dmem_req, mi.ready, wi.valid); end
            tick();
        end
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        #1;
        checks++; if (wi.valid !== 1'b1 || wi.mem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_result: valid=%b rdata=%h want 1/deadbeef", wi.valid, wi.mem_rdata); end
        checks++; if (wi.pc !== 32'h300 || wi.rd !== 5'd7 || wi.reg_wsel !== REG_WSEL_MEM) begin errors++; $display("FAIL lw_fields: pc=%h rd=%0d wsel=%0d want 00000300/7/1", wi.pc, wi.rd, wi.reg_wsel); end
        tick();
    endtask

    task automatic test_backpressure();
        wi.ready = 1'b0;
        set_m(32'h400, 5'd4, 1'b0, 1'b0, MEM_W, 32'h40, 32'h0);
        tick();
        set_m(32'h404, 5'd5, 1'b0, 1'b0, MEM_W, 32'h44, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (mi.ready !== 1'b0 || wi.valid !== 1'b1) begin errors++; $display("FAIL bp_hold_%0d: mready=%b wvalid=%b want 0/1", i, mi.ready, wi.valid); end
            checks++; if (wi.pc !== 32'h400 || wi.alu_out !== 32'h410 || wi.rd !== 5'd4) begin errors++; $display("FAIL bp_stable_%0d: pc=%h alu_out=%h rd=%0d want 00000400/00000410/4", i, wi.pc, wi.alu_out, wi.rd); end
            tick();
        end
        wi.ready = 1'b1;
        #1;
        checks++; if (mi.ready !== 1'b1) begin errors++; $display("FAIL bp_release_mready: got %b want 1", mi.ready); end
        tick();
        mi.valid = 1'b0;
        #1;
        checks++; if (wi.valid !== 1'b1 || wi.pc !== 32'h404) begin errors++; $display("FAIL bp_next: valid=%b pc=%h want 1/00000404", wi.valid, wi.pc); end
        tick();
        checks++; if (wi.valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", wi.valid); end
    endtask

    task automatic test_half_store();
        wi.ready = 1'b1;
        set_m(32'h500, 5'd0, 1'b0, 1'b1, MEM_H, 32'h0000_0002, 32'h0000_1234);
        tick();
        mi.valid = 1'b0;
        dmem_gnt = 1'b1;
        #1;
        checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h0) begin errors++; $display("FAIL sh_req: req=%b addr=%h want 1/00000000", dmem_req, dmem_addr); end
        checks++; if (dmem_be !== 4'b1100 || dmem_wdata !== 32'h1234_0000) begin errors++; $display("FAIL sh_lane: be=%b wdata=%h want 1100/12340000", dmem_be, dmem_wdata); end
        tick();
        dmem_gnt = 1'b0;
        #1;
        checks++; if (wi.valid !== 1'b1 || dmem_req !== 1'b0) begin errors++; $display("FAIL sh_done: valid=%b req=%b want 1/0", wi.valid, dmem_req); end
        tick();
    endtask

    task automatic test_reset_in_wait();
        wi.ready = 1'b1;
        set_m(32'h600, 5'd9, 1'b1, 1'b0, MEM_W, 32'h3000, 32'h0);
        tick();
        mi.valid = 1'b0;
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        #1;
        checks++; if (dmem_req !== 1'b0 || mi.ready !== 1'b0 || wi.valid !== 1'b0) begin errors++; $display("FAIL rw_in_wait: req=%b mready=%b wvalid=%b want 0/0/0", dmem_req, mi.ready, wi.valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (wi.valid !== 1'b0 || dmem_req !== 1'b0 || mi.ready !== 1'b1) begin errors++; $display("FAIL rw_after: wvalid=%b req=%b mready=%b want 0/0/1", wi.valid, dmem_req, mi.ready); end
        checks++; if (wi.pc !== 32'h0 || dmem_addr !== 32'h0) begin errors++; $display("FAIL rw_cleared: pc=%h addr=%h want 0/0", wi.pc, dmem_addr); end
        tick();
        checks++; if (wi.valid !== 1'b0 || mi.ready !== 1'b1) begin errors++; $display("FAIL rw_idle: wvalid=%b mready=%b want 0/1", wi.valid, mi.ready); end
    endtask

    initial begin
        rst         = 1'b1;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        wi.ready    = 1'b0;
        mi.valid    = 1'b0;
        set_m(32'h0, 5'd0, 1'b0, 1'b0, MEM_W, 32'h0, 32'h0);
        mi.valid    = 1'b0;

        test_reset();
        test_alu_stream();
        test_byte_store();
        test_load_word();
        test_backpressure();
        test_half_store();
        test_reset_in_wait();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_mem.md
# core_mem

Memory-access stage of the in-order core, between execute and `core_wback`. Accepts one instruction per handshake from execute, issues at most one data-bus transaction for loads and stores, and presents the result through `w_if` to writeback. Store data is lane-aligned and byte enables are generated here. Raw load words are forwarded unmodified; writeback performs load extraction.

## Interface
- No parameters.
- `clk` — input, 1 — core clock.
- `rst` — input, 1 — synchronous, active-high reset.
- `m` — `m_if.slave` — from execute:
  - handshake: `valid`, `ready`
  - fields: `pc`, `rd`, `reg_wen`, `reg_wsel`, `mem_ren`, `mem_wen`, `mem_type`, `alu_out`, `alu_sum`, `imm`, `csr_value`, `rs2_data`
- `w` — `w_if.slave` — to `core_wback`:
  - handshake: `valid`, `ready`
  - fields: `pc`, `rd`, `reg_wen`, `reg_wsel`, `mem_type`, `alu_out`, `alu_sum`, `imm`, `csr_value`, `mem_rdata`
- `dmem_req` — output, 1 — bus request; held until granted.
- `dmem_we` — output, 1 — 1 = store.
- `dmem_addr` — output, 32 — `{alu_sum[31:2], 2'b00}`.
- `dmem_wdata` — output, 32 — lane-shifted store data.
- `dmem_be` — output, 4 — byte enables; `4'b0000` on loads.
- `dmem_gnt` — input, 1 — request accepted this cycle.
- `dmem_rvalid` — input, 1 — load data valid this cycle.
- `dmem_rdata` — input, 32 — load data.

## Operation
- There is a single instruction slot, controlled by FSM states `EMPTY`, `REQ`, `WAIT`, `FULL`.
- `m.ready = (state==EMPTY) || (state==FULL && w.ready)`.
- `w.valid = (state==FULL)`.
- `dmem_req = (state==REQ)`.
- On accept (`m.valid && m.ready`): all fields are captured into the slot. Next state:
  - `REQ` if `mem_ren || mem_wen`,
  - `FULL` otherwise.
- `REQ`: address, `we`, `wdata`, and `be` are driven from the slot and stay stable until `dmem_gnt`. On `dmem_gnt`:
  - store → `FULL`,
  - load → `WAIT`.
- `WAIT`: on `dmem_rvalid`, `dmem_rdata` is captured into slot `mem_rdata`; next state is `FULL`.
- `FULL`: if `w.ready` and no new accept, next state is `EMPTY`. A simultaneous consume and accept loads the new instruction (back-to-back, no bubble).
- `mem_rdata` is 0 for non-load instructions.
- Store alignment, with `off = alu_sum[1:0]`:
  - `wdata = rs2_data << (8*off)`.
  - `be`: `MEM_B` → `4'b0001<<off`; `MEM_H` → `4'b0011<<off`; `MEM_W` → `4'b1111`.
- Misaligned addresses are excluded upstream by execute. This block does no checking; high bits of an overflowing `be` shift are dropped.
- `mem_ren && mem_wen` together is illegal. A simulation assertion flags it.
- `dmem_rvalid` outside `WAIT` is ignored and flagged by assertion.

## Timing
- Reset values:
  - `state = EMPTY`; `w.valid = 0`; `m.ready = 1`
  - `dmem_req = 0`, `dmem_we = 0`, `dmem_be = 0`
  - `dmem_addr = 0`, `dmem_wdata = 0`
  - all slot fields = 0
- Reset during `REQ` or `WAIT` drops the instruction; `dmem_req` is 0 in the cycle after reset. The bus is reset in the same cycle, so no stale `rvalid` arrives.
- Latency, with the accept edge closing cycle N:
  - non-memory: `w.valid` in N+1.
  - store with immediate grant: `dmem_req` in N+1, `w.valid` in N+2.
  - load with `gnt` in N+1 and `rvalid` in N+2 (earliest legal): `w.valid` in N+3.
- `rvalid` never coincides with `gnt` (bus rule). Each cycle of `gnt` delay adds one cycle; each cycle of `rvalid` delay adds one cycle.
- Throughput: one non-memory instruction per cycle when `w.ready = 1`. Memory instructions are blocking: one in flight.
- `w` outputs are registered and stable while `w.valid && !w.ready`.

## Structure
- Package `rv` holds:
  - `regaddr_t`,
  - `mem_type_t` (`MEM_B`, `MEM_H`, `MEM_W`, `MEM_BU`, `MEM_HU`),
  - `reg_wsel_t` (`REG_WSEL_*`).
- The FSM state enum is local to `core_mem`.
- Sub-module `core_store` is purely combinational:
  - inputs: `rs2_data`, `mem_type`, `offset[1:0]`,
  - outputs: `bus_wdata`, `bus_be`.
- `core_store` mirrors `core_load` in writeback.

## Test plan
- **ALU op stream:** `pc = 0x100, 0x104, 0x108` back-to-back, `w.ready = 1` → `w.valid` on three consecutive cycles, starting one cycle after the first accept, with the fields passed through and `mem_rdata = 0`.
- **Byte store:** `MEM_B`, `alu_sum = 0x1003`, `rs2 = 0xAB`, `gnt` held low for 2 cycles → `dmem_req` high for 3 cycles with `addr = 0x1000`, `be = 4'b1000`, `wdata = 0xAB000000` stable throughout; `w.valid` in the cycle after `gnt`.
- **Load word:** `alu_sum = 0x2000`, `gnt` immediate, `rvalid` 3 cycles later with `rdata = 0xDEADBEEF` → `w.mem_rdata = 0xDEADBEEF`, `w.valid` in the cycle after `rvalid`, `m.ready = 0` throughout.
- **Backpressure:** `w.ready = 0` for 4 cycles with a result in `FULL` and `m.valid = 1` → `m.ready = 0` and `w` outputs stable; when `w.ready` rises, the next instruction is accepted the same cycle.
- **Halfword store:** `MEM_H`, `alu_sum = 0x0002`, `rs2 = 0x1234` → `be = 4'b1100`, `wdata = 0x12340000`.
- **Reset in WAIT:** assert `rst` for one cycle while a load waits → next cycle `state = EMPTY`, `w.valid = 0`, `dmem_req = 0`, `m.ready = 1`.
